// File: rtl/impact_mem_arbiter.sv
// rtl/impact_mem_arbiter.sv - two-requester round-robin arbiter onto a byte-wide banked memory
// Each 32-bit transaction is serialised into four byte beats; reads are reassembled into rsp_rdata.
module impact_mem_arbiter #(
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqA_valid,
    input  logic        reqA_we,
    input  logic [11:0] reqA_addr,
    input  logic [31:0] reqA_wdata,
    input  logic [3:0]  reqA_be,
    output logic        reqA_ready,
    input  logic        reqB_valid,
    input  logic        reqB_we,
    input  logic [11:0] reqB_addr,
    input  logic [31:0] reqB_wdata,
    input  logic [3:0]  reqB_be,
    output logic        reqB_ready,
    output logic        rspA_valid,
    output logic        rspB_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        mem_ReadEnable,
    output logic        mem_WriteEnable,
    output logic [1:0]  mem_Bank_Select,
    output logic [9:0]  mem_Word_Select,
    output logic [1:0]  mem_Byte_Select,
    output logic [7:0]  mem_Data_In,
    input  logic [7:0]  mem_Data_Out
);
    typedef enum logic [1:0] {IDLE, BEAT, DRAIN, RESP} state_t;

    state_t        state, state_next;
    logic [1:0]    cnt;
    logic          prio_b;
    logic          owner_b;
    logic          lat_we;
    logic [11:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_be;
    logic          grant_a, grant_b;
    logic [READ_LAT-1:0] cap_vld;
    logic [1:0]    cap_idx [READ_LAT];

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE) begin
            if (reqA_valid && reqB_valid) begin
                grant_b = prio_b;
                grant_a = !prio_b;
            end else begin
                grant_a = reqA_valid;
                grant_b = reqB_valid;
            end
        end
    end

    // Grants are combinational from IDLE, so gate them while reset is held.
    assign reqA_ready = grant_a & rst_n;
    assign reqB_ready = grant_b & rst_n;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (grant_a || grant_b) state_next = BEAT;
            BEAT:  if (cnt == 2'd3) state_next = lat_we ? RESP : DRAIN;
            DRAIN: if (cnt == 2'(READ_LAT - 1)) state_next = RESP;
            RESP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy            = (state != IDLE);
        rspA_valid      = (state == RESP) && !owner_b;
        rspB_valid      = (state == RESP) && owner_b;
        mem_ReadEnable  = 1'b0;
        mem_WriteEnable = 1'b0;
        mem_Bank_Select = 2'd0;
        mem_Word_Select = 10'd0;
        mem_Byte_Select = 2'd0;
        mem_Data_In     = 8'd0;
        if (state == BEAT) begin
            mem_Bank_Select = lat_addr[11:10];
            mem_Word_Select = lat_addr[9:0];
            mem_Byte_Select = cnt;
            mem_ReadEnable  = !lat_we;
            mem_WriteEnable = lat_we && lat_be[cnt];
            if (mem_WriteEnable) mem_Data_In = lat_wdata[{cnt, 3'b000} +: 8];
        end
    end

    // cnt walks the beats and then the drain cycles; it restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            prio_b    <= 1'b0;
            owner_b   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= 12'd0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? 2'd0 : cnt + 2'd1;
            if (grant_a || grant_b) begin
                prio_b    <= grant_a;
                owner_b   <= grant_b;
                lat_we    <= grant_b ? reqB_we    : reqA_we;
                lat_addr  <= grant_b ? reqB_addr  : reqA_addr;
                lat_wdata <= grant_b ? reqB_wdata : reqA_wdata;
                lat_be    <= grant_b ? reqB_be    : reqA_be;
            end
        end
    end

    // Delay line tracks which byte each read strobe returns READ_LAT cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld   <= '0;
            rsp_rdata <= 32'd0;
            for (int i = 0; i < READ_LAT; i++) cap_idx[i] <= 2'd0;
        end else begin
            cap_vld[0] <= mem_ReadEnable;
            cap_idx[0] <= mem_Byte_Select;
            for (int i = 1; i < READ_LAT; i++) begin
                cap_vld[i] <= cap_vld[i-1];
                cap_idx[i] <= cap_idx[i-1];
            end
            if (cap_vld[READ_LAT-1])
                rsp_rdata[{cap_idx[READ_LAT-1], 3'b000} +: 8] <= mem_Data_Out;
        end
    end
endmodule

// File: doc/impact_mem_arbiter.md
IMPACT_MEM_ARBITER -- requirements
Module: impact_mem_arbiter

Interface
REQ-001 SHALL have parameter READ_LAT, default 1: cycles from the mem_ReadEnable cycle to valid mem_Data_Out; legal range 1..3.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports reqA_valid / reqB_valid, input, 1 bit each: the requester has a pending transaction.
REQ-005 SHALL have ports reqA_we / reqB_we, input, 1 bit each: 1 = write, 0 = read.
REQ-006 SHALL have ports reqA_addr / reqB_addr, input, 12 bits each: [11:10] bank, [9:0] word.
REQ-007 SHALL have ports reqA_wdata / reqB_wdata, input, 32 bits each: write data, byte k = bits [8k+7:8k].
REQ-008 SHALL have ports reqA_be / reqB_be, input, 4 bits each: write byte enables; ignored on reads.
REQ-009 SHALL have ports reqA_ready / reqB_ready, output, 1 bit each: one-cycle acceptance pulse.
REQ-010 SHALL have ports rspA_valid / rspB_valid, output, 1 bit each: one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata, output, 32 bits: read data, valid while rspA_valid or rspB_valid is high.
REQ-012 SHALL have port busy, output, 1 bit: high in every non-IDLE state.
REQ-013 SHALL have ports mem_ReadEnable and mem_WriteEnable, output, 1 bit each: memory strobes.
REQ-014 SHALL have ports mem_Bank_Select (2 bits), mem_Word_Select (10 bits) and mem_Byte_Select (2 bits), all outputs: the memory address.
REQ-015 SHALL have port mem_Data_In, output, 8 bits: byte written to the memory.
REQ-016 SHALL have port mem_Data_Out, input, 8 bits: byte read from the memory.

Function
REQ-017 SHALL implement FSM states IDLE, BEAT, DRAIN and RESP.
REQ-018 In IDLE with any valid request, SHALL pulse the winner's ready, latch its payload and go to BEAT; the accept cycle is T.
REQ-019 SHALL arbitrate round-robin: a single requester wins; if both are valid, the requester not granted last wins; after reset, A has priority.
REQ-020 SHALL pulse at most one ready per cycle, and never outside IDLE.
REQ-021 BEAT SHALL last exactly 4 cycles (T+1..T+4); beat k drives Byte_Select = k, with Bank_Select and Word_Select taken from the latched address.
REQ-022 On a write, SHALL assert WriteEnable in beat k only if be[k]=1, with mem_Data_In = byte k; masked beats still take their cycle.
REQ-023 On a read, SHALL assert ReadEnable in all 4 beats and capture byte k from mem_Data_Out at cycle T+1+k+READ_LAT into rsp_rdata[8k+7:8k].
REQ-024 SHALL never assert ReadEnable and WriteEnable together; mem_Data_In SHALL be 0 when WriteEnable is low.
REQ-025 After BEAT, a read SHALL stay in DRAIN for READ_LAT cycles; a write SHALL skip DRAIN.
REQ-026 RESP SHALL last one cycle and pulse the owner's rsp_valid: at T+5 for a write, at T+5+READ_LAT for a read; the next state is IDLE.
REQ-027 For writes, rsp_rdata SHALL hold its previous value.
REQ-028 The earliest next acceptance SHALL be the cycle after RESP, so back-to-back writes complete one every 6 cycles.
REQ-029 A requester dropping valid before its ready pulse SHALL forfeit that arbitration without error.

Reset
REQ-030 While rst_n=0, all outputs SHALL be 0, the FSM SHALL be in IDLE and the round-robin pointer SHALL favour A.
REQ-031 Reset mid-transaction SHALL immediately deassert the memory strobes, abort the remaining beats, and produce no rsp_valid.

Verification
REQ-032 A writes addr 0xC05, wdata 0xDEADBEEF, be 0xF -> beats T+1..T+4 write bytes EF, BE, AD, DE at bank 3, word 5, bytes 0..3; rspA_valid pulses at T+5.
REQ-033 A reads 0xC05 with READ_LAT=1 against a memory model -> rsp_rdata = 0xDEADBEEF, rspA_valid pulses at T+6, ReadEnable is high exactly 4 cycles.
REQ-034 A write with be 0x5 -> WriteEnable high only at T+1 and T+3; bytes 1 and 3 of the memory are unchanged.
REQ-035 A and B held valid continuously -> grants go A, B, A, B; no ready pulse while busy=1.
REQ-036 rst_n pulled low at T+2 of a write -> strobes go 0 asynchronously; only byte 0 is written; no rsp_valid; after release, a new request is accepted in IDLE.
REQ-037 READ_LAT=3 read -> bytes captured at T+4..T+7, rsp_valid at T+8, ReadEnable and WriteEnable never high together.
